// File: rtl/cmd_dispatch.sv
// Queues 4-byte commands in a FIFO and hands each one to its addressed slave(s) with per-slave valid/ready.
// Broadcasts to all slaves on BCAST_ID; drops unmapped ids. Optional issue timeout when CMD_TIMEOUT_EN is defined.
module cmd_dispatch #(
   parameter int unsigned NUM_SLV     = 2,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [7:0]  DEV_BASE    = 8'h01,
   parameter logic [7:0]  BCAST_ID    = 8'hFF,
   parameter int unsigned TIMEOUT_CYC = 1000
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic [7:0]         dev_id,
   input  logic [7:0]         mod_id,
   input  logic [7:0]         cmd_addr,
   input  logic [7:0]         cmd_data,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   output logic [7:0]         slv_mod_id,
   output logic [7:0]         slv_addr,
   output logic [7:0]         slv_data,
   output logic [NUM_SLV-1:0] slv_vld,
   input  logic [NUM_SLV-1:0] slv_rdy,
   output logic               busy,
   output logic               err_unmap,
   output logic               err_timeout,
   output logic [7:0]         drop_cnt
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [7:0] dev_id;
      logic [7:0] mod_id;
      logic [7:0] addr;
      logic [7:0] data;
   } cmd_t;

   typedef enum logic {IDLE, ISSUE} state_t;

   cmd_t             fifo_mem [FIFO_DEPTH];
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fifo_full, fifo_empty, push, pop;

   state_t             state_q, state_d;
   logic [NUM_SLV-1:0] pend_q, pend_d, pend_left, head_mask;
   logic [7:0]         mod_q, mod_d, addr_q, addr_d, data_q, data_d;
   logic               err_unmap_q, err_unmap_d, err_timeout_q, err_timeout_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic [1:0]         drop_inc;
   logic [8:0]         drop_sum;
   logic               timed_out;
`ifdef CMD_TIMEOUT_EN
   logic [15:0]        timer_q, timer_d;
`endif

   // Broadcast wins over the unicast window if BCAST_ID happens to fall inside it.
   function automatic logic [NUM_SLV-1:0] decode(input logic [7:0] dev);
      logic [7:0] off;
      off    = dev - DEV_BASE;
      decode = '0;
      if (dev == BCAST_ID)
         decode = '1;
      else if (32'(off) < NUM_SLV)
         decode = NUM_SLV'(1) << off;
   endfunction

   assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign cmd_rdy    = !fifo_full && !rst;
   assign push       = cmd_vld && cmd_rdy;
   assign head       = fifo_mem[rd_ptr_q];
   assign head_mask  = decode(head.dev_id);

   always_comb begin
      state_d       = state_q;
      pend_d        = pend_q;
      mod_d         = mod_q;
      addr_d        = addr_q;
      data_d        = data_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      err_unmap_d   = 1'b0;
      err_timeout_d = 1'b0;
      drop_inc      = 2'd0;
      pop           = 1'b0;
      timed_out     = 1'b0;
      pend_left     = pend_q & ~slv_rdy;
`ifdef CMD_TIMEOUT_EN
      timer_d       = timer_q;
`endif

      case (state_q)
         IDLE: pop = !fifo_empty;
         ISSUE: begin
`ifdef CMD_TIMEOUT_EN
            timer_d   = timer_q + 16'd1;
            timed_out = (pend_left != '0) && (timer_q >= 16'(TIMEOUT_CYC - 1));
`endif
            pend_d = timed_out ? '0 : pend_left;
            if (timed_out) begin
               err_timeout_d = 1'b1;
               drop_inc      = drop_inc + 2'd1;
            end
            if (timed_out || pend_left == '0) begin
               if (fifo_empty)
                  state_d = IDLE;
               else
                  pop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Loading the next command overrides whatever the current one left behind.
      if (pop) begin
         mod_d    = head.mod_id;
         addr_d   = head.addr;
         data_d   = head.data;
         pend_d   = head_mask;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef CMD_TIMEOUT_EN
         timer_d  = 16'd0;
`endif
         if (head_mask == '0) begin
            state_d     = IDLE;
            err_unmap_d = 1'b1;
            drop_inc    = drop_inc + 2'd1;
         end else begin
            state_d = ISSUE;
         end
      end

      if (push)
         wr_ptr_d = wr_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      drop_sum   = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
      drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state_q       <= IDLE;
         pend_q        <= '0;
         mod_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         err_unmap_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         drop_cnt_q    <= '0;
`ifdef CMD_TIMEOUT_EN
         timer_q       <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pend_q        <= pend_d;
         mod_q         <= mod_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         err_unmap_q   <= err_unmap_d;
         err_timeout_q <= err_timeout_d;
         drop_cnt_q    <= drop_cnt_d;
`ifdef CMD_TIMEOUT_EN
         timer_q       <= timer_d;
`endif
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push)
         fifo_mem[wr_ptr_q] <= {dev_id, mod_id, cmd_addr, cmd_data};
   end

   assign slv_vld     = pend_q;
   assign slv_mod_id  = mod_q;
   assign slv_addr    = addr_q;
   assign slv_data    = data_q;
   assign busy        = !fifo_empty || (state_q == ISSUE);
   assign err_unmap   = err_unmap_q;
   assign err_timeout = err_timeout_q;
   assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Scoreboard bench for cmd_dispatch: accepted commands are routed to per-slave expectation queues by an
// address-rule model; a monitor pops and compares on every slave handshake.
module tb_cmd_dispatch;

   localparam int NS   = 2;
   localparam int BASE = 1;

   logic          clk_sys = 1'b0;
   logic          rst;
   logic [7:0]    dev_id, mod_id, cmd_addr, cmd_data;
   logic          cmd_vld, cmd_rdy;
   logic [7:0]    slv_mod_id, slv_addr, slv_data;
   logic [NS-1:0] slv_vld, slv_rdy;
   logic          busy, err_unmap, err_timeout;
   logic [7:0]    drop_cnt;

   int checks = 0, failures = 0;

   typedef struct packed {
      logic [7:0] m;
      logic [7:0] a;
      logic [7:0] d;
   } exp_t;

   exp_t          exp_q [NS][$];
   exp_t          mon_e;
   int            model_drops = 0, model_unmaps = 0, unmap_seen = 0, timeout_seen = 0;
   logic          rnd_rdy = 1'b0, skip_hold = 1'b0;
   logic [NS-1:0] prev_vld = '0, prev_rdy = '0;
   logic [23:0]   prev_f = '0;

   always #5 clk_sys = ~clk_sys;

   cmd_dispatch #(
      .NUM_SLV(NS), .FIFO_DEPTH(4), .DEV_BASE(8'h01), .BCAST_ID(8'hFF), .TIMEOUT_CYC(20)
   ) dut (
      .clk_sys(clk_sys), .rst(rst),
      .dev_id(dev_id), .mod_id(mod_id), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
      .slv_mod_id(slv_mod_id), .slv_addr(slv_addr), .slv_data(slv_data),
      .slv_vld(slv_vld), .slv_rdy(slv_rdy),
      .busy(busy), .err_unmap(err_unmap), .err_timeout(err_timeout), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Reference routing: broadcast to all, unicast by id offset, anything else is a drop.
   task automatic model_push(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                             input logic [7:0] v);
      exp_t e;
      int   idx;
      e   = {m, a, v};
      idx = int'(d) - BASE;
      if (d == 8'hFF) begin
         for (int k = 0; k < NS; k++) exp_q[k].push_back(e);
      end else if (idx >= 0 && idx < NS) begin
         exp_q[idx].push_back(e);
      end else begin
         model_drops++;
         model_unmaps++;
      end
   endtask

   always @(negedge clk_sys) begin
      if (rst) begin
         for (int k = 0; k < NS; k++) exp_q[k].delete();
         model_drops  = 0;
         model_unmaps = 0;
         unmap_seen   = 0;
         timeout_seen = 0;
         prev_vld     = '0;
         prev_rdy     = '0;
      end else begin
         if (cmd_vld && cmd_rdy) model_push(dev_id, mod_id, cmd_addr, cmd_data);
         if (err_unmap) unmap_seen++;
         if (err_timeout) timeout_seen++;
         if (!skip_hold && (prev_vld & ~prev_rdy) != '0) begin
            chk("hold_vld", slv_vld, prev_vld & ~prev_rdy);
            chk("hold_fields", {slv_mod_id, slv_addr, slv_data}, prev_f);
         end
         for (int k = 0; k < NS; k++) begin
            if (slv_vld[k] && slv_rdy[k]) begin
               checks++;
               if (exp_q[k].size() == 0) begin
                  failures++;
                  $display("FAIL unexpected_issue slv%0d: got %h expected nothing", k,
                           {slv_mod_id, slv_addr, slv_data});
               end else begin
                  mon_e = exp_q[k].pop_front();
                  if (mon_e != {slv_mod_id, slv_addr, slv_data}) begin
                     failures++;
                     $display("FAIL slv%0d_fields: got %h expected %h", k,
                              {slv_mod_id, slv_addr, slv_data}, mon_e);
                  end
               end
            end
         end
         prev_vld = slv_vld;
         prev_rdy = slv_rdy;
         prev_f   = {slv_mod_id, slv_addr, slv_data};
      end
   end

   always @(posedge clk_sys) begin
      if (rnd_rdy) begin
         #1;
         slv_rdy = NS'($urandom);
      end
   end

   task automatic push_cmd(input logic [7:0] d, input logic [7:0] m, input logic [7:0] a,
                           input logic [7:0] v);
      int   n;
      logic acc;
      n        = 0;
      acc      = 1'b0;
      dev_id   = d;
      mod_id   = m;
      cmd_addr = a;
      cmd_data = v;
      cmd_vld  = 1'b1;
      do begin
         acc = cmd_rdy;
         tick();
         n++;
      end while (!acc && n < 200);
      cmd_vld = 1'b0;
      chk("push_accept", acc, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || slv_vld != '0) && n < 3000) begin
         tick();
         n++;
      end
      chk("idle_within_bound", (n < 3000), 1);
      tick();
      tick();
   endtask

   task automatic chk_drained(input string name);
      for (int k = 0; k < NS; k++) chk(name, exp_q[k].size(), 0);
   endtask

   initial begin
      rst = 1'b1; cmd_vld = 1'b0; dev_id = '0; mod_id = '0; cmd_addr = '0; cmd_data = '0;
      slv_rdy = '0;
      tick();
      tick();
      chk("rdy_in_reset", cmd_rdy, 0);
      rst = 1'b0;
      tick();
      chk("rst_vld", slv_vld, 0);
      chk("rst_fields", {slv_mod_id, slv_addr, slv_data}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errs", {err_unmap, err_timeout}, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rdy_after_reset", cmd_rdy, 1);

      // Unicast to slave 1 with ready held: one-cycle valid, two cycles after acceptance.
      slv_rdy = 2'b11;
      push_cmd(8'h02, 8'h11, 8'h22, 8'h33);
      chk("uni_vld_e0", slv_vld, 2'b00);
      tick();
      chk("uni_vld_e1", slv_vld, 2'b10);
      chk("uni_fields", {slv_mod_id, slv_addr, slv_data}, 24'h112233);
      tick();
      chk("uni_vld_e2", slv_vld, 2'b00);
      chk("uni_drop", drop_cnt, 0);
      wait_idle();

      // Broadcast with staggered readies.
      slv_rdy = 2'b00;
      push_cmd(8'hFF, 8'hA1, 8'hB2, 8'hC3);
      chk("bc_vld_e0", slv_vld, 2'b00);
      tick();
      chk("bc_vld_both", slv_vld, 2'b11);
      tick();
      tick();
      chk("bc_vld_wait", slv_vld, 2'b11);
      slv_rdy = 2'b01;
      tick();
      chk("bc_vld_s1only", slv_vld, 2'b10);
      chk("bc_fields", {slv_mod_id, slv_addr, slv_data}, 24'hA1B2C3);
      slv_rdy = 2'b00;
      tick();
      tick();
      chk("bc_vld_s1wait", slv_vld, 2'b10);
      slv_rdy = 2'b10;
      tick();
      chk("bc_vld_done", slv_vld, 2'b00);
      slv_rdy = 2'b11;
      wait_idle();

      // Fill: one command sits in issue, four in the FIFO, the sixth is refused.
      slv_rdy = 2'b00;
      for (int i = 0; i < 6; i++) begin
         dev_id = 8'h01; mod_id = 8'(i); cmd_addr = 8'(i + 16); cmd_data = 8'(i + 32);
         cmd_vld = 1'b1;
         chk($sformatf("fill_rdy%0d", i), cmd_rdy, (i < 5));
         tick();
      end
      cmd_vld = 1'b0;
      chk("fill_busy", busy, 1);
      chk("fill_queued", exp_q[0].size(), 5);
      slv_rdy = 2'b01;
      wait_idle();
      chk_drained("fill_drained");

      // Unmapped id followed by a valid one.
      slv_rdy = 2'b11;
      push_cmd(8'h10, 8'h01, 8'h02, 8'h03);
      chk("unmap_e0", err_unmap, 0);
      push_cmd(8'h01, 8'h44, 8'h55, 8'h66);
      chk("unmap_pulse", err_unmap, 1);
      chk("unmap_no_vld", slv_vld, 2'b00);
      tick();
      chk("unmap_pulse_end", err_unmap, 0);
      chk("unmap_next_vld", slv_vld, 2'b01);
      chk("unmap_drop", drop_cnt, 1);
      wait_idle();

      // Randomised traffic and ready patterns.
      rnd_rdy = 1'b1;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    dev_id = 8'h01;
            2:       dev_id = 8'h02;
            3:       dev_id = 8'hFF;
            4:       dev_id = 8'h00;
            default: dev_id = 8'($urandom);
         endcase
         mod_id   = 8'($urandom);
         cmd_addr = 8'($urandom);
         cmd_data = 8'($urandom);
         cmd_vld  = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_vld = 1'b0;
      rnd_rdy = 1'b0;
      tick();
      slv_rdy = 2'b11;
      wait_idle();
      chk_drained("rnd_drained");
      chk("rnd_drop", drop_cnt, (model_drops > 255) ? 255 : model_drops);
      chk("rnd_unmap_pulses", unmap_seen, model_unmaps);

`ifdef CMD_TIMEOUT_EN
      begin
         int n;
         slv_rdy   = 2'b00;
         skip_hold = 1'b1;
         push_cmd(8'h01, 8'h77, 8'h88, 8'h99);
         tick();
         n = 0;
         while (slv_vld[0] && n < 40) begin
            n++;
            tick();
         end
         chk("to_vld_cycles", n, 20);
         chk("to_pulse", err_timeout, 1);
         if (exp_q[0].size() > 0) void'(exp_q[0].pop_front());
         model_drops++;
         chk("to_drop", drop_cnt, (model_drops > 255) ? 255 : model_drops);
         tick();
         chk("to_pulse_end", err_timeout, 0);
         skip_hold = 1'b0;
         slv_rdy   = 2'b11;
         wait_idle();
      end
`else
      chk("no_timeout_pulses", timeout_seen, 0);
`endif

      // Saturation of the drop counter.
      slv_rdy  = 2'b11;
      dev_id   = 8'h40;
      cmd_vld  = 1'b1;
      for (int i = 0; i < 270; i++) tick();
      cmd_vld = 1'b0;
      wait_idle();
      chk("drop_sat", drop_cnt, 255);
      chk("drop_sat_model", drop_cnt, (model_drops > 255) ? 255 : model_drops);

      // Reset while issuing with commands still queued.
      slv_rdy = 2'b00;
      push_cmd(8'h02, 8'h01, 8'h01, 8'h01);
      push_cmd(8'h02, 8'h02, 8'h02, 8'h02);
      push_cmd(8'h02, 8'h03, 8'h03, 8'h03);
      chk("mid_vld", slv_vld, 2'b10);
      rst = 1'b1;
      tick();
      chk("mrst_vld", slv_vld, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_rdy", cmd_rdy, 0);
      chk("mrst_fields", {slv_mod_id, slv_addr, slv_data}, 0);
      chk("mrst_drop", drop_cnt, 0);
      chk("mrst_errs", {err_unmap, err_timeout}, 0);
      rst = 1'b0;
      tick();
      chk("post_rdy", cmd_rdy, 1);
      chk("post_busy", busy, 0);
      slv_rdy = 2'b11;
      push_cmd(8'h01, 8'h5A, 8'hA5, 8'h3C);
      wait_idle();
      chk_drained("post_drained");
      chk("post_drop", drop_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
